// File: rtl/dom_pkg.sv
// Shared definitions for the DOM share-compression datapath.
// Contents:
//   DomNBits   - default number of lanes compressed in parallel
//   DomCntW    - default width of the randomness-consumption counter
//   DomMaxBits - widest lane vector supported
//   dom_share2_t - a 2-share lane vector (share 0 and share 1)
package dom_pkg;

    localparam int unsigned DomNBits   = 4;
    localparam int unsigned DomCntW    = 16;
    localparam int unsigned DomMaxBits = 16;

    typedef struct packed {
        logic [DomMaxBits-1:0] s1;
        logic [DomMaxBits-1:0] s0;
    } dom_share2_t;

endpackage

// File: rtl/dom_cross_reg.sv
// Blind-and-register stage for the cross-domain partial products.
// Both cross terms of a lane vector are masked with the same fresh word and
// captured together, so neither term ever reaches logic downstream unmasked.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   load_i     - capture blinded cross terms this cycle
//   clr_i      - zero the stored terms (ignored while load_i is high)
//   p01_i      - cross term share0 x share1
//   p10_i      - cross term share1 x share0
//   rnd_i      - fresh mask word
//   c0_o, c1_o - registered blinded cross terms
module dom_cross_reg
    import dom_pkg::*;
#(
    parameter int unsigned N_BITS = DomNBits
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_i,
    input  logic              clr_i,
    input  logic [N_BITS-1:0] p01_i,
    input  logic [N_BITS-1:0] p10_i,
    input  logic [N_BITS-1:0] rnd_i,
    output logic [N_BITS-1:0] c0_o,
    output logic [N_BITS-1:0] c1_o
);

    logic [N_BITS-1:0] c0_q, c0_d;
    logic [N_BITS-1:0] c1_q, c1_d;

    always_comb begin
        c0_d = c0_q;
        c1_d = c1_q;
        if (load_i) begin
            c0_d = p01_i ^ rnd_i;
            c1_d = p10_i ^ rnd_i;
        end else if (clr_i) begin
            c0_d = '0;
            c1_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            c0_q <= '0;
            c1_q <= '0;
        end else begin
            c0_q <= c0_d;
            c1_q <= c1_d;
        end
    end

    assign c0_o = c0_q;
    assign c1_o = c1_q;

endmodule

// File: rtl/dom_share_compress_unit.sv
// Two-stage DOM compression of 2-share partial products into a registered
// 2-share result, with valid/ready on both sides and a randomness gate.
// Stage 1 holds the blinded cross terms and the raw inner terms; stage 2
// recombines them (q0 = i0 ^ c0, q1 = i1 ^ c1) so q0 ^ q1 equals the XOR
// of all four partial products regardless of the mask.
// Ports:
//   clk, rst_n          - clock, asynchronous active-low reset
//   in_valid / in_ready - input handshake (in_ready also needs rnd_valid)
//   p00, p01, p10, p11  - partial products per lane
//   rnd, rnd_valid      - fresh mask word and its availability
//   out_valid/out_ready - output handshake
//   q0, q1              - compressed shares
//   rnd_used            - saturating count of accepted input sets
// Build option: DOM_STALE_CLEAR_EN zeroes stage data once a stage drains
// without being refilled; handshake timing is unchanged.
module dom_share_compress_unit
    import dom_pkg::*;
#(
    parameter int unsigned N_BITS = DomNBits,
    parameter int unsigned CNT_W  = DomCntW
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [N_BITS-1:0] p00,
    input  logic [N_BITS-1:0] p01,
    input  logic [N_BITS-1:0] p10,
    input  logic [N_BITS-1:0] p11,
    input  logic [N_BITS-1:0] rnd,
    input  logic              rnd_valid,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [N_BITS-1:0] q0,
    output logic [N_BITS-1:0] q1,
    output logic [CNT_W-1:0]  rnd_used
);

    logic              s1_valid_q, s1_valid_d;
    logic [N_BITS-1:0] i0_q, i0_d;
    logic [N_BITS-1:0] i1_q, i1_d;
    logic [N_BITS-1:0] c0, c1;
    logic              out_valid_q, out_valid_d;
    logic [N_BITS-1:0] q0_q, q0_d;
    logic [N_BITS-1:0] q1_q, q1_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;

    logic accept;
    logic s1_adv;
    logic out_drain;
    logic s1_clr;
    logic s2_clr;

    assign s1_adv    = s1_valid_q & (~out_valid_q | out_ready);
    assign in_ready  = rnd_valid & (~s1_valid_q | s1_adv);
    assign accept    = in_valid & in_ready;
    assign out_drain = out_valid_q & out_ready;

`ifdef DOM_STALE_CLEAR_EN
    assign s1_clr = s1_adv & ~accept;
    assign s2_clr = out_drain & ~s1_adv;
`else
    assign s1_clr = 1'b0;
    assign s2_clr = 1'b0;
`endif

    dom_cross_reg #(
        .N_BITS (N_BITS)
    ) u_cross (
        .clk    (clk),
        .rst_n  (rst_n),
        .load_i (accept),
        .clr_i  (s1_clr),
        .p01_i  (p01),
        .p10_i  (p10),
        .rnd_i  (rnd),
        .c0_o   (c0),
        .c1_o   (c1)
    );

    always_comb begin
        s1_valid_d = s1_valid_q;
        i0_d       = i0_q;
        i1_d       = i1_q;
        if (accept) begin
            s1_valid_d = 1'b1;
            i0_d       = p00;
            i1_d       = p11;
        end else if (s1_adv) begin
            s1_valid_d = 1'b0;
            if (s1_clr) begin
                i0_d = '0;
                i1_d = '0;
            end
        end
    end

    always_comb begin
        out_valid_d = out_valid_q;
        q0_d        = q0_q;
        q1_d        = q1_q;
        if (s1_adv) begin
            out_valid_d = 1'b1;
            q0_d        = i0_q ^ c0;
            q1_d        = i1_q ^ c1;
        end else if (out_drain) begin
            out_valid_d = 1'b0;
            if (s2_clr) begin
                q0_d = '0;
                q1_d = '0;
            end
        end
    end

    // Saturate instead of wrapping so the count never understates use.
    always_comb begin
        cnt_d = cnt_q;
        if (accept && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid_q  <= 1'b0;
            i0_q        <= '0;
            i1_q        <= '0;
            out_valid_q <= 1'b0;
            q0_q        <= '0;
            q1_q        <= '0;
            cnt_q       <= '0;
        end else begin
            s1_valid_q  <= s1_valid_d;
            i0_q        <= i0_d;
            i1_q        <= i1_d;
            out_valid_q <= out_valid_d;
            q0_q        <= q0_d;
            q1_q        <= q1_d;
            cnt_q       <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign q0        = q0_q;
    assign q1        = q1_q;
    assign rnd_used  = cnt_q;

endmodule

// File: tb/tb_dom_share_compress_unit.sv
module tb_dom_share_compress_unit;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready, in_ready_s;
    logic [3:0] p00, p01, p10, p11, rnd;
    logic       rnd_valid;
    logic       out_valid, out_valid_s;
    logic       out_ready;
    logic [3:0] q0, q1, q0_s, q1_s;
    logic [15:0] rnd_used;
    logic [3:0]  rnd_used_s;

    dom_share_compress_unit #(.N_BITS(4), .CNT_W(16)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .p00(p00), .p01(p01), .p10(p10), .p11(p11), .rnd(rnd), .rnd_valid(rnd_valid),
        .out_valid(out_valid), .out_ready(out_ready), .q0(q0), .q1(q1), .rnd_used(rnd_used)
    );

    // Narrow-counter instance driven identically, used for saturation checks.
    dom_share_compress_unit #(.N_BITS(4), .CNT_W(4)) dut_sat (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready_s),
        .p00(p00), .p01(p01), .p10(p10), .p11(p11), .rnd(rnd), .rnd_valid(rnd_valid),
        .out_valid(out_valid_s), .out_ready(out_ready), .q0(q0_s), .q1(q1_s),
        .rnd_used(rnd_used_s)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [3:0] q0;
        logic [3:0] q1;
        logic [3:0] sum;
        bit         sweep;
    } exp_t;

    exp_t sb[$];
    int   tests = 0;
    int   fails = 0;
    int   cnt_model = 0;
    bit   sweep_mode = 0;
    bit   seen[16];
    bit   stall_prev = 0;
    logic [3:0] held0, held1;
    logic [3:0] last_q0 = 4'h0, last_q1 = 4'h0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor / scoreboard: observes handshakes at the falling edge.
    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            stall_prev = 0;
        end else begin
            if (stall_prev) begin
                chk("stall_valid", {31'b0, out_valid}, 32'd1);
                chk("stall_q0", {28'b0, q0}, {28'b0, held0});
                chk("stall_q1", {28'b0, q1}, {28'b0, held1});
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    chk("unexpected_output", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("q0", {28'b0, q0}, {28'b0, e.q0});
                    chk("q1", {28'b0, q1}, {28'b0, e.q1});
                    chk("share_sum", {28'b0, q0 ^ q1}, {28'b0, e.sum});
                    if (e.sweep) seen[q0] = 1'b1;
                    last_q0 = e.q0;
                    last_q1 = e.q1;
                end
            end
            stall_prev = out_valid && !out_ready;
            held0 = q0;
            held1 = q1;
            chk("rnd_used", {16'b0, rnd_used}, (cnt_model > 65535) ? 32'd65535 : cnt_model);
            chk("rnd_used_sat", {28'b0, rnd_used_s}, (cnt_model > 15) ? 32'd15 : cnt_model);
            if (in_valid && in_ready) begin
                e.q0    = p00 ^ p01 ^ rnd;
                e.q1    = p11 ^ p10 ^ rnd;
                e.sum   = p00 ^ p01 ^ p10 ^ p11;
                e.sweep = sweep_mode;
                sb.push_back(e);
                cnt_model++;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drain();
        int i;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        i = 0;
        while ((sb.size() != 0 || out_valid) && i < 60) begin
            @(negedge clk);
            i++;
        end
        chk("drain_done", {31'b0, (sb.size() != 0 || out_valid)}, 32'd0);
    endtask

    task automatic set_basic(input logic [3:0] r);
        p00 = 4'hA; p01 = 4'h3; p10 = 4'h5; p11 = 4'hC; rnd = r;
    endtask

    task automatic set_rand();
        p00 = 4'($urandom_range(0, 15));
        p01 = 4'($urandom_range(0, 15));
        p10 = 4'($urandom_range(0, 15));
        p11 = 4'($urandom_range(0, 15));
        rnd = 4'($urandom_range(0, 15));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        int nseen;
        rst_n = 1'b0; in_valid = 1'b0; rnd_valid = 1'b0; out_ready = 1'b0;
        p00 = '0; p01 = '0; p10 = '0; p11 = '0; rnd = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("reset_out_valid", {31'b0, out_valid}, 32'd0);
        chk("reset_q0", {28'b0, q0}, 32'd0);
        chk("reset_q1", {28'b0, q1}, 32'd0);
        chk("reset_rnd_used", {16'b0, rnd_used}, 32'd0);
        tick();
        rst_n = 1'b1;

        // Basic transaction and two-cycle latency.
        tick();
        set_basic(4'h6);
        in_valid = 1'b1; rnd_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        chk("basic_in_ready", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("basic_lat1_valid", {31'b0, out_valid}, 32'd0);
        chk("basic_rnd_used", {16'b0, rnd_used}, 32'd1);
        @(negedge clk);
        chk("basic_lat2_valid", {31'b0, out_valid}, 32'd1);
        chk("basic_q0", {28'b0, q0}, 32'hF);
        chk("basic_q1", {28'b0, q1}, 32'hF);
        drain();

        // Randomness gate.
        tick();
        set_basic(4'h9);
        in_valid = 1'b1; rnd_valid = 1'b0;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("gate_in_ready", {31'b0, in_ready}, 32'd0);
            chk("gate_rnd_used", {16'b0, rnd_used}, 32'd1);
        end
        tick();
        rnd_valid = 1'b1;
        @(negedge clk);
        chk("gate_release_ready", {31'b0, in_ready}, 32'd1);
        tick();
        in_valid = 1'b0;
        @(negedge clk);
        chk("gate_rnd_used_after", {16'b0, rnd_used}, 32'd2);
        drain();

        // Backpressure: only two sets fit.
        tick();
        out_ready = 1'b0;
        acc = 0;
        for (int k = 0; k < 4; k++) begin
            set_rand();
            in_valid = 1'b1;
            @(negedge clk);
            if (in_ready) acc++;
            tick();
        end
        chk("bp_accepted", acc, 32'd2);
        @(negedge clk);
        chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
        repeat (3) tick();
        in_valid = 1'b0;
        drain();

        // Mask independence sweep at full throughput.
        tick();
        sweep_mode = 1'b1;
        for (int r = 0; r < 16; r++) begin
            set_basic(4'(r));
            in_valid = 1'b1;
            @(negedge clk);
            chk("sweep_in_ready", {31'b0, in_ready}, 32'd1);
            tick();
        end
        in_valid = 1'b0;
        sweep_mode = 1'b0;
        drain();
        nseen = 0;
        for (int v = 0; v < 16; v++) if (seen[v]) nseen++;
        chk("sweep_distinct_q0", nseen, 32'd16);

        // Randomized traffic.
        for (int k = 0; k < 400; k++) begin
            tick();
            set_rand();
            in_valid  = ($urandom_range(0, 3) != 0);
            rnd_valid = ($urandom_range(0, 7) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
        end
        rnd_valid = 1'b1;
        drain();

        // Reset with both stages full.
        tick();
        out_ready = 1'b0;
        for (int k = 0; k < 2; k++) begin
            set_rand();
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        tick();
        #2;
        rst_n = 1'b0;
        sb.delete();
        cnt_model = 0;
        #1;
        chk("rst_mid_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_mid_q0", {28'b0, q0}, 32'd0);
        chk("rst_mid_q1", {28'b0, q1}, 32'd0);
        chk("rst_mid_rnd_used", {16'b0, rnd_used}, 32'd0);
        chk("rst_mid_rnd_used_sat", {28'b0, rnd_used_s}, 32'd0);
        repeat (2) tick();
        rst_n = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("post_rst_no_output", {31'b0, out_valid}, 32'd0);
        end

        // Saturation of the narrow counter.
        tick();
        for (int k = 0; k < 20; k++) begin
            set_rand();
            in_valid = 1'b1;
            tick();
        end
        in_valid = 1'b0;
        @(negedge clk);
        chk("sat_rnd_used_sat", {28'b0, rnd_used_s}, 32'hF);
        chk("sat_rnd_used", {16'b0, rnd_used}, 32'd20);
        drain();
`ifdef DOM_STALE_CLEAR_EN
        chk("idle_q0", {28'b0, q0}, 32'd0);
        chk("idle_q1", {28'b0, q1}, 32'd0);
`else
        chk("idle_q0", {28'b0, q0}, {28'b0, last_q0});
        chk("idle_q1", {28'b0, q1}, {28'b0, last_q1});
`endif

        repeat (2) tick();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
